// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side (master) reports hazard sources and memory status and
// receives the per-buffer enable/flush strobes; the controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int R = 3,
    parameter int S = 15
);
    logic [R-1:0] id_rs;
    logic [R-1:0] id_rt;
    logic [R-1:0] ex_rd;
    logic         ex_memread;
    logic         branch_taken;
    logic         mem_req;
    logic         mem_ready;
    logic         err_clr;
    logic         cnt_clr;

    logic         pc_en;
    logic         ifid_en;
    logic         ifid_flush;
    logic         idex_en;
    logic         idex_flush;
    logic         exmem_en;
    logic         memwb_bubble;
    logic         mem_err;
    logic [S:0]   stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rd, ex_memread, branch_taken,
               mem_req, mem_ready, err_clr, cnt_clr,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_bubble, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rd, ex_memread, branch_taken,
               mem_req, mem_ready, err_clr, cnt_clr,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_bubble, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use hazards, taken-branch
// flushes and memory wait states into write-enable and flush strobes for the
// PC and the four pipeline buffers. A wait-state FSM times out into a sticky
// error state, and a saturating counter tallies cycles with the PC held.
module pipe_hazard_ctrl #(
    parameter int R        = 3,
    parameter int S        = 15,
    parameter int WAIT_MAX = 8
) (
    input logic                 clk,
    input logic                 rst,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int W = $clog2(WAIT_MAX);
    localparam logic [W-1:0] WAIT_LAST = W'(WAIT_MAX - 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_ERR     = 2'd2;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_bubble;
    } strobe_t;

    localparam strobe_t S_NORM      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam strobe_t S_FREEZE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam strobe_t S_BRANCH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam strobe_t S_LOAD_USE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam strobe_t S_FLUSH_ALL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam strobe_t S_RESET     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [W-1:0] wait_q, wait_d;
    logic         err_q, err_d;
    logic [S:0]   stall_q;
    logic         load_use;
    logic         mem_stall;
    strobe_t      run_strb;
    strobe_t      strb;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use  = bus.ex_memread && (bus.ex_rd != '0) &&
                       ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    // Strobes the pipeline would get in RUN: memory stall > branch > load-use.
    always_comb begin
        run_strb = S_NORM;
        if (mem_stall)             run_strb = S_FREEZE;
        else if (bus.branch_taken) run_strb = S_BRANCH;
        else if (load_use)         run_strb = S_LOAD_USE;
    end

    // Next-state logic and same-cycle strobes for each controller state.
    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        strb    = S_NORM;
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                strb = run_strb;
                if (mem_stall) begin
                    state_d = ST_MEMWAIT;
                    wait_d  = W'(1);
                end
            end
            ST_MEMWAIT: begin
                if (bus.mem_ready) begin
                    // Release cycle: branch/load-use are honoured right away.
                    strb    = run_strb;
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    strb = S_FREEZE;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + W'(1);
                    end
                end
            end
            ST_ERR: begin
                if (bus.err_clr) begin
                    strb    = S_FLUSH_ALL;
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                end else begin
                    strb = S_FREEZE;
                end
            end
            default: begin
                strb    = S_FREEZE;
                state_d = ST_RUN;
                wait_d  = '0;
                err_d   = 1'b0;
            end
        endcase
        // Reset drives the strobes directly so the pipeline is held immediately.
        if (!rst) strb = S_RESET;
    end

    // State, wait counter and sticky error register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Saturating count of cycles with the PC held; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_q <= '0;
        end else if (!strb.pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.pc_en        = strb.pc_en;
    assign bus.ifid_en      = strb.ifid_en;
    assign bus.ifid_flush   = strb.ifid_flush;
    assign bus.idex_en      = strb.idex_en;
    assign bus.idex_flush   = strb.idex_flush;
    assign bus.exmem_en     = strb.exmem_en;
    assign bus.memwb_bubble = strb.memwb_bubble;
    assign bus.mem_err      = err_q;
    assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Each step drives one cycle of
// inputs just after posedge and queues the expected strobes, error flag and
// stall count; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
    localparam int R        = 3;
    localparam int S        = 3;
    localparam int WAIT_MAX = 8;

    // Strobe vector order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble
    localparam logic [6:0] NORM   = 7'b1101010;
    localparam logic [6:0] LU     = 7'b0001110;
    localparam logic [6:0] BR     = 7'b1111110;
    localparam logic [6:0] FRZ    = 7'b0000001;
    localparam logic [6:0] ALL1   = 7'b1111111;
    localparam logic [6:0] RSTV   = 7'b0010101;

    typedef struct packed {
        logic [R-1:0] rs;
        logic [R-1:0] rt;
        logic [R-1:0] rd;
        logic         memread;
        logic         br;
        logic         req;
        logic         rdy;
        logic         eclr;
        logic         cclr;
    } stim_t;

    typedef struct {
        string      tag;
        logic [6:0] vec;
        logic       err;
        logic [S:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic [S:0] exp_stall = '0;

    pipe_hazard_ctrl_if #(.R(R), .S(S)) bus ();

    pipe_hazard_ctrl #(.R(R), .S(S), .WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic stim_t mk(input int rs, input int rt, input int rd, input bit memread,
                                 input bit br, input bit req, input bit rdy,
                                 input bit eclr, input bit cclr);
        stim_t s;
        s.rs = R'(rs); s.rt = R'(rt); s.rd = R'(rd);
        s.memread = memread; s.br = br; s.req = req; s.rdy = rdy;
        s.eclr = eclr; s.cclr = cclr;
        return s;
    endfunction

    function automatic logic [6:0] strobes();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_en, bus.memwb_bubble};
    endfunction

    task automatic apply(input stim_t s);
        bus.id_rs        = s.rs;
        bus.id_rt        = s.rt;
        bus.ex_rd        = s.rd;
        bus.ex_memread   = s.memread;
        bus.branch_taken = s.br;
        bus.mem_req      = s.req;
        bus.mem_ready    = s.rdy;
        bus.err_clr      = s.eclr;
        bus.cnt_clr      = s.cclr;
    endtask

    // One clock of stimulus with its expected strobes and mem_err.
    task automatic step(input string tag, input stim_t s, input logic [6:0] vec, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.tag = tag; e.vec = vec; e.err = err; e.cnt = exp_stall;
        sb.push_back(e);
        if (s.cclr) exp_stall = '0;
        else if (!vec[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".strobes"}, strobes(), e.vec);
            check({e.tag, ".mem_err"}, bus.mem_err, e.err);
            check({e.tag, ".stall_cnt"}, bus.stall_cnt, e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t idle, stall, clr;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        clr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1'b0;
        apply(idle);
        #12;
        check("reset.strobes", strobes(), RSTV);
        check("reset.mem_err", bus.mem_err, 0);
        check("reset.stall_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: idle
        for (int i = 0; i < 5; i++) step("idle", idle, NORM, 0);

        // 2: load-use detection, register 0 never hazards
        step("lu_rt", mk(0, 3, 3, 1, 0, 0, 0, 0, 0), LU, 0);
        step("after_lu", idle, NORM, 0);
        step("lu_r0", mk(0, 0, 0, 1, 0, 0, 0, 0, 0), NORM, 0);
        step("lu_rs", mk(5, 1, 5, 1, 0, 0, 0, 0, 0), LU, 0);
        step("no_match", mk(4, 6, 5, 1, 0, 0, 0, 0, 0), NORM, 0);
        step("no_load", mk(5, 5, 5, 0, 0, 0, 0, 0, 0), NORM, 0);

        // 3: branch overrides load-use
        step("br_lu", mk(0, 3, 3, 1, 1, 0, 0, 0, 0), BR, 0);
        step("after_br", clr, NORM, 0);

        // 4: three wait cycles then release; zero-wait access; release with branch
        for (int i = 0; i < 3; i++) step("mw3", stall, FRZ, 0);
        step("mw_release", mk(0, 0, 0, 0, 0, 1, 1, 0, 0), NORM, 0);
        step("after_mw", idle, NORM, 0);
        step("zero_wait", mk(0, 0, 0, 0, 0, 1, 1, 0, 0), NORM, 0);
        step("mw_br_enter", stall, FRZ, 0);
        step("mw_br_ignored", mk(0, 3, 3, 1, 1, 1, 0, 0, 0), FRZ, 0);
        step("mw_release_br", mk(0, 0, 0, 0, 1, 1, 1, 0, 0), BR, 0);
        step("mw_release_lu", mk(0, 2, 2, 1, 0, 0, 0, 0, 0), LU, 0);
        step("clr4", clr, NORM, 0);

        // 5: timeout into ERR, late ready ignored, err_clr flush
        step("eclr_run", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), NORM, 0);
        for (int i = 0; i < 8; i++) step("to_wait", stall, FRZ, 0);
        step("err_hold", stall, FRZ, 1);
        step("err_late_ready", mk(0, 0, 0, 0, 0, 1, 1, 0, 0), FRZ, 1);
        step("err_clr", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ALL1, 1);
        step("after_err", idle, NORM, 0);
        step("clr5", clr, NORM, 0);

        // 6: saturation, clear, async reset mid-MEMWAIT
        for (int i = 0; i < 8; i++) step("sat_wait", stall, FRZ, 0);
        for (int i = 0; i < 12; i++) step("sat_err", stall, FRZ, 1);
        step("sat_clr_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ALL1, 1);
        step("sat_hold", idle, NORM, 0);
        step("sat_cnt_clr", clr, NORM, 0);
        step("after_clr", idle, NORM, 0);
        step("mw_a", stall, FRZ, 0);
        step("mw_b", stall, FRZ, 0);
        drain();

        #2;
        rst = 1'b0;
        exp_stall = '0;
        #1;
        check("async_rst.strobes", strobes(), RSTV);
        check("async_rst.mem_err", bus.mem_err, 0);
        check("async_rst.stall_cnt", bus.stall_cnt, 0);
        apply(idle);
        @(posedge clk);
        #1;
        check("rst_held.stall_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", idle, NORM, 0);
        step("post_rst2", idle, NORM, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 4 pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards, taken-branch flushes and memory wait states.
- Drives per-buffer write-enable and flush/bubble strobes.
- Includes a memory-wait timeout FSM with sticky error, plus a saturating stall counter for performance monitoring.

Parameters:
R, 3, register-address width (bits)
S, 15, MSB index of stall counter (counter is S+1 bits)
WAIT_MAX, 8, max MEM wait cycles before timeout (>=2)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
id_rs  in  R  source reg A of instruction in ID
id_rt  in  R  source reg B of instruction in ID
ex_rd  in  R  destination reg of instruction in EX
ex_memread  in  1  EX instruction is a load
branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  MEM-stage instruction accesses memory
mem_ready  in  1  memory completes access this cycle
err_clr  in  1  leave ERR state, flush pipeline
cnt_clr  in  1  synchronous clear of stall counter
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID buffer write enable
ifid_flush  out  1  IF/ID load NOP
idex_en  out  1  ID/EX buffer write enable
idex_flush  out  1  ID/EX load bubble (ctrl=0)
exmem_en  out  1  EX/MEM buffer write enable
memwb_bubble  out  1  MEM/WB loads bubble (no writeback)
mem_err  out  1  sticky timeout flag
stall_cnt  out  S+1  cycles with pc_en=0, saturating

Behaviour:
- Asynchronous active-low reset: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
- While rst=0: all *_en=0; ifid_flush=idex_flush=memwb_bubble=1.
- Strobes are combinational from state+inputs (0-cycle latency). State, wait_cnt, mem_err and stall_cnt are registered on posedge clk.
- Default in RUN with no events: all *_en=1, all flush/bubble=0.
- Load-use hazard LU = ex_memread && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt). Register 0 never hazards.
- Priority in RUN: memory stall > branch > load-use.
  - Memory stall (mem_req && !mem_ready): pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1; next state=MEMWAIT, wait_cnt<=1.
  - Branch (branch_taken): pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=1. A simultaneous LU is ignored, since the ID instruction is flushed.
  - LU: pc_en=ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. One bubble; the hazard clears next cycle as the load advances.
  - mem_req && mem_ready in RUN: zero-wait access, treated as no memory stall.
- MEMWAIT: all strobes as in memory stall. branch_taken and LU are ignored and re-evaluated after release.
  - mem_ready=1: strobes take RUN values for that same cycle (branch/LU honoured); next=RUN, wait_cnt<=0.
  - Else if wait_cnt==WAIT_MAX-1: next=ERR, mem_err<=1.
  - Else wait_cnt<=wait_cnt+1.
- ERR: frozen as in MEMWAIT; mem_err stays 1; mem_ready is ignored.
  - err_clr=1: that cycle pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=idex_flush=memwb_bubble=1; next=RUN, mem_err<=0.
  - err_clr in RUN/MEMWAIT: no effect.
- stall_cnt: +1 on each clock where rst=1 and pc_en=0. Holds at all-ones, no wrap. cnt_clr=1 sets it to 0, overriding increment.
- Reset asserted mid-MEMWAIT/ERR: immediate return to RUN, counters zeroed. Memory transaction abandonment is the memory unit's responsibility.
- Illegal state encoding: next=RUN.

Test Plan:
1. Reset then idle (no events, 5 clocks) -> all enables 1, flushes 0, stall_cnt=0, mem_err=0.
2. ex_memread=1, ex_rd=3, id_rt=3 for 1 cycle -> pc_en=ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
3. branch_taken=1 together with LU condition -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
4. mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_bubble=1, release on the ready cycle, stall_cnt=3, state RUN.
5. mem_req=1, mem_ready never, WAIT_MAX=8 -> mem_err=1 after 8 frozen cycles. A late mem_ready has no effect. err_clr -> full flush for 1 cycle, then mem_err=0 and RUN.
6. Force stall_cnt to all-ones via a long ERR with S=3 -> holds at 4'hF. cnt_clr -> 0. rst low mid-MEMWAIT -> all outputs at reset values asynchronously.
